// File: rtl/seg_ctrl_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
// Holds the FSM state encoding and the modular index helper used for round-robin order.
package seg_ctrl_pkg;

   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic {
      StIdle = 1'b0,
      StShow = 1'b1
   } state_e;

   // Wraps a value in [0, 2n) back into [0, n).
   function automatic int unsigned rr_wrap(int unsigned a, int unsigned n);
      return (a >= n) ? a - n : a;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, modulo NUM_REQ.
// Returns the one-hot winner, its index and whether any request is pending.
module rr_arbiter
   import seg_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [PTR_W-1:0]   win_idx,
   output logic               any_req
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      winner  = '0;
      win_idx = '0;
      any_req = 1'b0;
      idx     = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = PTR_W'(rr_wrap(32'(rr_ptr) + i, NUM_REQ));
         if (!any_req && req[idx]) begin
            any_req      = 1'b1;
            winner[idx]  = 1'b1;
            win_idx      = idx;
         end
      end
   end

endmodule

// File: rtl/seg_display_arbiter.sv
// Time-shares one 4-digit seven-segment display between NUM_REQ requesters.
// Round-robin winner's value is latched and held for HOLD_CYCLES, ending with a done pulse.
module seg_display_arbiter
   import seg_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned HOLD_CYCLES = 50_000_000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*DATA_W-1:0] data_i,
   output logic [NUM_REQ-1:0]        grant_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic                      busy_o,
   output logic [31:0]               number_o
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   value_q, value_d;

   logic [NUM_REQ-1:0]  winner;
   logic [PTR_W-1:0]    win_idx;
   logic                any_req;
   logic [DATA_W-1:0]   sel_data;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .req     (req_i),
      .rr_ptr  (rr_ptr_q),
      .winner  (winner),
      .win_idx (win_idx),
      .any_req (any_req)
   );

   always_comb begin
      sel_data = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (win_idx == PTR_W'(k)) sel_data = data_i[k*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      cnt_d    = cnt_q;
      value_d  = value_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               state_d  = StShow;
               grant_d  = winner;
               value_d  = sel_data;
               cnt_d    = CNT_LOAD;
               rr_ptr_d = PTR_W'(rr_wrap(32'(win_idx) + 1, NUM_REQ));
            end
         end
         StShow: begin
            if (cnt_q == '0) begin
               state_d = StIdle;
               grant_d = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         cnt_q    <= '0;
         value_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         cnt_q    <= cnt_d;
         value_q  <= value_d;
      end
   end

   // The last display cycle is the one with the counter at zero.
   always_comb begin
      busy_o   = (state_q == StShow);
      grant_o  = grant_q;
      done_o   = (state_q == StShow && cnt_q == '0) ? grant_q : '0;
      number_o = 32'(value_q);
   end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with NUM_REQ=4, HOLD_CYCLES=4.
// Inputs change and outputs are checked 1 time unit after each rising edge.
module tb_seg_display_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_i;
   logic [63:0] data_i;
   logic [3:0]  grant_o;
   logic [3:0]  done_o;
   logic        busy_o;
   logic [31:0] number_o;

   int passed = 0;
   int total  = 0;

   seg_display_arbiter #(
      .NUM_REQ     (4),
      .DATA_W      (16),
      .HOLD_CYCLES (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (req_i),
      .data_i   (data_i),
      .grant_o  (grant_o),
      .done_o   (done_o),
      .busy_o   (busy_o),
      .number_o (number_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(string tag, logic [3:0] g, logic [3:0] d, logic b, logic [31:0] n);
      total++;
      assert ({grant_o, done_o, busy_o, number_o} === {g, d, b, n}) passed++;
      else $error("FAIL %s: observed grant=%b done=%b busy=%b number=%h expected grant=%b done=%b busy=%b number=%h",
                  tag, grant_o, done_o, busy_o, number_o, g, d, b, n);
   endtask

   task automatic set_data(int k, logic [15:0] v);
      data_i[k*16 +: 16] = v;
   endtask

   // Four SHOW cycles for requester k showing v; done on the last one.
   task automatic run_grant(string tag, int k, logic [15:0] v);
      logic [3:0] oh;
      oh = 4'(1 << k);
      for (int i = 0; i < 4; i++) begin
         step();
         check(tag, oh, (i == 3) ? oh : 4'b0000, 1'b1, {16'h0000, v});
      end
   endtask

   task automatic idle_gap(string tag, logic [15:0] v);
      step();
      check(tag, 4'b0000, 4'b0000, 1'b0, {16'h0000, v});
   endtask

   initial begin
      rst_n  = 1'b1;
      req_i  = 4'b0000;
      data_i = '0;
      #2 rst_n = 1'b0;
      #1 check("reset", 4'b0000, 4'b0000, 1'b0, 32'h0);
      step();
      step();
      rst_n = 1'b1;

      // 1: no requests
      for (int i = 0; i < 20; i++) begin
         step();
         check("t1_idle", 4'b0000, 4'b0000, 1'b0, 32'h0);
      end

      // 2: sole requester 2, re-granted after one idle cycle
      set_data(2, 16'h1234);
      req_i = 4'b0100;
      run_grant("t2_first", 2, 16'h1234);
      idle_gap("t2_gap", 16'h1234);
      run_grant("t2_regrant", 2, 16'h1234);
      req_i = 4'b0000;
      idle_gap("t2_end", 16'h1234);

      // 6: rr_ptr is 3, requests 0 and 1 -> wrap to 0, then 1
      set_data(0, 16'h1111);
      set_data(1, 16'h2222);
      req_i = 4'b0011;
      run_grant("t6_wrap0", 0, 16'h1111);
      idle_gap("t6_gap", 16'h1111);
      run_grant("t6_then1", 1, 16'h2222);
      req_i = 4'b0000;
      idle_gap("t6_end", 16'h2222);

      // Serve requester 3 so rr_ptr returns to 0
      set_data(3, 16'h4444);
      req_i = 4'b1000;
      run_grant("t3_pre3", 3, 16'h4444);
      idle_gap("t3_pregap", 16'h4444);

      // 3: all requesting -> 0,1,2,3,0
      set_data(2, 16'h3333);
      req_i = 4'b1111;
      run_grant("t3_g0", 0, 16'h1111);
      idle_gap("t3_gap0", 16'h1111);
      run_grant("t3_g1", 1, 16'h2222);
      idle_gap("t3_gap1", 16'h2222);
      run_grant("t3_g2", 2, 16'h3333);
      idle_gap("t3_gap2", 16'h3333);
      run_grant("t3_g3", 3, 16'h4444);
      idle_gap("t3_gap3", 16'h4444);
      run_grant("t3_g0b", 0, 16'h1111);
      req_i = 4'b0000;
      idle_gap("t3_end", 16'h1111);

      // 4: rr_ptr is 1; data and req change mid-SHOW are ignored
      set_data(1, 16'hAAAA);
      req_i = 4'b0010;
      step();
      check("t4_c1", 4'b0010, 4'b0000, 1'b1, 32'h0000AAAA);
      set_data(1, 16'hBBBB);
      req_i = 4'b0000;
      step();
      check("t4_c2", 4'b0010, 4'b0000, 1'b1, 32'h0000AAAA);
      step();
      check("t4_c3", 4'b0010, 4'b0000, 1'b1, 32'h0000AAAA);
      step();
      check("t4_c4", 4'b0010, 4'b0010, 1'b1, 32'h0000AAAA);
      idle_gap("t4_gap", 16'hAAAA);

      // 5: reset during SHOW cycle 2, then rr_ptr back at 0
      set_data(2, 16'h1234);
      req_i = 4'b0100;
      step();
      check("t5_c1", 4'b0100, 4'b0000, 1'b1, 32'h00001234);
      step();
      check("t5_c2", 4'b0100, 4'b0000, 1'b1, 32'h00001234);
      #2 rst_n = 1'b0;
      #1 check("t5_async", 4'b0000, 4'b0000, 1'b0, 32'h0);
      step();
      check("t5_held", 4'b0000, 4'b0000, 1'b0, 32'h0);
      req_i = 4'b1001;
      rst_n = 1'b1;
      run_grant("t5_req0", 0, 16'h1111);
      req_i = 4'b0000;
      idle_gap("t5_end", 16'h1111);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
